mcu0_intc: RTL and testbench

Programmable interrupt controller for the mcu0 16-bit core. It collects up to seven external interrupt sources, latches their rising edges and applies a per-source enable mask. It then arbitrates among pending sources and drives the core's `interrupt`/`irq[2:0]` inputs through an acknowledge/end-of-interrupt handshake. Only one interrupt is ever in service, matching the core's single LR and `isInterrupted` model.

---
 rtl/mcu0_intc.sv | 155 +++++++++++++++
 tb/tb_mcu0_intc.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu0_intc.sv
// rtl/mcu0_intc.sv - mcu0 programmable interrupt controller
//
// Collects seven edge-triggered sources (irq_in[7:1]), masks them, arbitrates
// and drives the core's interrupt/irq pair through an ack / eoi handshake.
// Only one interrupt is ever in service.
//
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   irq_in[7:0]           raw request lines, bit 0 ignored
//   ack, eoi              one-cycle pulses from the core (taken / IRET)
//   cfg_we, cfg_addr,     register write strobe, select and data
//   cfg_wdata
//   cfg_rdata             combinational read data for cfg_addr
//   interrupt, irq[2:0]   request and vector index to the core
//
// Registers: 0 MASK (R/W), 1 PEND (write-1-clear), 2 STAT, 3 reads 0.
// Build option: MCU0_INTC_ROTATE_EN selects rotating priority; when undefined
// priority is fixed with index 1 highest.

module mcu0_intc (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] irq_in,
  input  logic       ack,
  input  logic       eoi,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] cfg_rdata,
  output logic       interrupt,
  output logic [2:0] irq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] mask, pend, sample, prev;
  logic [7:0] eligible, edge_set, pend_clr;
  logic [2:0] insvc, insvc_nxt, winner, last_view;
  logic       ack_take;

  // Bit 0 never exists: vector 0 is the reset vector.
  assign eligible = pend & mask & 8'hFE;
  assign edge_set = sample & ~prev & 8'hFE;
  assign ack_take = (state == REQ) && ack;

`ifdef MCU0_INTC_ROTATE_EN
  logic [2:0] last;

  // k-th candidate after 'base' in the cyclic order 1..7 (0 is skipped).
  function automatic logic [2:0] rot_idx(input logic [2:0] base, input logic [2:0] k);
    logic [3:0] s;
    s = {1'b0, base} + {1'b0, k};
    if (s >= 4'd7) s = s - 4'd7;
    return s[2:0] + 3'd1;
  endfunction

  // Walk from the far end so the nearest candidate after 'last' wins.
  always_comb begin
    winner = 3'd0;
    for (int k = 6; k >= 0; k--) begin
      if (eligible[rot_idx(last, 3'(k))]) winner = rot_idx(last, 3'(k));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                     last <= 3'd7;
    else if (state == SERVICE && eoi) last <= insvc;
  end

  assign last_view = last;
`else
  // Walk downward so the lowest eligible index is left in winner.
  always_comb begin
    winner = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  assign last_view = 3'd0;
`endif

  // A new edge overrides a same-cycle clear, so pend_clr is applied first.
  always_comb begin
    pend_clr = 8'h00;
    if (cfg_we && cfg_addr == 2'd1) pend_clr = cfg_wdata;
    if (ack_take)                   pend_clr[insvc] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask   <= 8'h00;
      pend   <= 8'h00;
      sample <= 8'h00;
      prev   <= 8'h00;
    end else begin
      sample <= irq_in;
      prev   <= sample;
      pend   <= ((pend & ~pend_clr) | edge_set) & 8'hFE;
      if (cfg_we && cfg_addr == 2'd0) mask <= cfg_wdata & 8'hFE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      insvc <= 3'd0;
    end else begin
      state <= state_nxt;
      insvc <= insvc_nxt;
    end
  end

  // Withdrawal in REQ looks at registered PEND/MASK, so a disabling write
  // drops the request one edge after it lands.
  always_comb begin
    state_nxt = state;
    insvc_nxt = insvc;
    case (state)
      IDLE: begin
        if (|eligible) begin
          insvc_nxt = winner;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (ack)                              state_nxt = SERVICE;
        else if (!(pend[insvc] & mask[insvc])) state_nxt = IDLE;
      end
      SERVICE: begin
        if (eoi) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign interrupt = (state == REQ);
  assign irq       = interrupt ? insvc : 3'd0;

  always_comb begin
    cfg_rdata = 8'h00;
    case (cfg_addr)
      2'd0:    cfg_rdata = mask;
      2'd1:    cfg_rdata = pend;
      2'd2:    cfg_rdata = {state, last_view, insvc};
      default: cfg_rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_mcu0_intc.sv
// tb/tb_mcu0_intc.sv - self-checking bench for mcu0_intc

module tb_mcu0_intc;

  logic       clock;
  logic       reset_n;
  logic [7:0] irq_in;
  logic       ack;
  logic       eoi;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       interrupt;
  logic [2:0] irq;

  int tests = 0;
  int fails = 0;
  bit check_en = 0;

  mcu0_intc dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .irq_in    (irq_in),
    .ack       (ack),
    .eoi       (eoi),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .interrupt (interrupt),
    .irq       (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: phase 0 idle, 1 requesting, 2 in service.
  bit [7:0] m_mask = 0, m_pend = 0, m_smp = 0, m_prv = 0;
  int       m_st = 0, m_insvc = 0;
`ifdef MCU0_INTC_ROTATE_EN
  int       m_last = 7;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    int start, i;
`ifdef MCU0_INTC_ROTATE_EN
    start = (m_last % 7) + 1;
`else
    start = 1;
`endif
    for (int k = 0; k < 7; k++) begin
      i = ((start - 1 + k) % 7) + 1;
      if (m_pend[i] && m_mask[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_mask = 0; m_pend = 0; m_smp = 0; m_prv = 0; m_st = 0; m_insvc = 0;
`ifdef MCU0_INTC_ROTATE_EN
    m_last = 7;
`endif
  endtask

  task automatic model_step();
    bit [7:0] sets, clr, np;
    int w, ost, oins;
    ost  = m_st;
    oins = m_insvc;
    sets = m_smp & ~m_prv & 8'hFE;
    clr  = 8'h00;
    if (cfg_we && cfg_addr == 2'd1) clr = cfg_wdata;
    if (ost == 1 && ack) clr[oins] = 1'b1;
    np = ((m_pend & ~clr) | sets) & 8'hFE;
    case (ost)
      0: begin
        w = pick();
        if (w != 0) begin m_insvc = w; m_st = 1; end
      end
      1: begin
        if (ack) m_st = 2;
        else if (!(m_pend[oins] && m_mask[oins])) m_st = 0;
      end
      default: begin
        if (eoi) begin
`ifdef MCU0_INTC_ROTATE_EN
          m_last = oins;
`endif
          m_st = 0;
        end
      end
    endcase
    m_pend = np;
    if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata & 8'hFE;
    m_prv = m_smp;
    m_smp = irq_in;
  endtask

  function automatic logic [7:0] exp_rd(input logic [1:0] a);
    logic [2:0] lb;
    logic [1:0] sb;
    logic [2:0] ib;
`ifdef MCU0_INTC_ROTATE_EN
    lb = m_last[2:0];
`else
    lb = 3'd0;
`endif
    sb = m_st[1:0];
    ib = m_insvc[2:0];
    case (a)
      2'd0:    return m_mask;
      2'd1:    return m_pend;
      2'd2:    return {sb, lb, ib};
      default: return 8'h00;
    endcase
  endfunction

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) model_reset();
    else          model_step();
  end

  // Compare process: outputs settle after the rising edge, checked on the falling one.
  initial forever begin
    @(negedge clock);
    if (check_en) begin
      chk("interrupt", interrupt, (m_st == 1) ? 1 : 0);
      chk("irq", irq, (m_st == 1) ? m_insvc : 0);
      chk("cfg_rdata", cfg_rdata, exp_rd(cfg_addr));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic look();
    @(negedge clock);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [7:0] exp);
    #1;
    cfg_addr = a;
    #1;
    chk(name, cfg_rdata, exp);
  endtask

  task automatic pulse_irq(input logic [7:0] b);
    irq_in = b; step(); irq_in = 8'h00;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; step(); eoi = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; irq_in = 8'h00; ack = 1'b0; eoi = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
    step(); step();
    reset_n = 1'b1;
    check_en = 1'b1;

    // Reset state
    look();
    chk("rst_interrupt", interrupt, 1'b0);
    chk("rst_irq", irq, 3'd0);
    rd("rst_mask", 2'd0, 8'h00);
    rd("rst_pend", 2'd1, 8'h00);
`ifdef MCU0_INTC_ROTATE_EN
    rd("rst_stat", 2'd2, 8'h38);
`else
    rd("rst_stat", 2'd2, 8'h00);
`endif
    rd("reg3", 2'd3, 8'h00);

    // Single source 3: latency, ack, stat
    wr(2'd0, 8'hFE);
    pulse_irq(8'h08);
    look(); chk("t1_int_n0", interrupt, 1'b0);
    step();
    look(); chk("t1_int_n1", interrupt, 1'b0); rd("t1_pend", 2'd1, 8'h08);
    step();
    look(); chk("t1_int_n2", interrupt, 1'b1); chk("t1_irq", irq, 3'd3);
    pulse_ack();
    look(); chk("t1_int_ack", interrupt, 1'b0); rd("t1_pend_ack", 2'd1, 8'h00);
`ifdef MCU0_INTC_ROTATE_EN
    rd("t1_stat", 2'd2, 8'hBB);
`else
    rd("t1_stat", 2'd2, 8'h83);
`endif
    pulse_eoi();
`ifdef MCU0_INTC_ROTATE_EN
    look(); rd("t1_stat_eoi", 2'd2, 8'h1B);
`else
    look(); rd("t1_stat_eoi", 2'd2, 8'h03);
`endif

    // Simultaneous sources 2 and 5
    wr(2'd0, 8'h24);
    pulse_irq(8'h24); step(); step();
`ifdef MCU0_INTC_ROTATE_EN
    look(); chk("t2_first", irq, 3'd5);
`else
    look(); chk("t2_first", irq, 3'd2);
`endif
    pulse_ack(); pulse_eoi();
    look(); chk("t2_gap", interrupt, 1'b0);
    step();
`ifdef MCU0_INTC_ROTATE_EN
    look(); chk("t2_second", irq, 3'd2);
`else
    look(); chk("t2_second", irq, 3'd5);
`endif
    pulse_ack(); pulse_eoi();
    pulse_irq(8'h04); step(); step();
    look(); chk("t2_solo", irq, 3'd2);
    pulse_ack(); pulse_eoi();
    pulse_irq(8'h24); step(); step();
`ifdef MCU0_INTC_ROTATE_EN
    look(); chk("t2_after2_first", irq, 3'd5);
`else
    look(); chk("t2_after2_first", irq, 3'd2);
`endif
    pulse_ack(); pulse_eoi(); step();
`ifdef MCU0_INTC_ROTATE_EN
    look(); chk("t2_after2_second", irq, 3'd2);
`else
    look(); chk("t2_after2_second", irq, 3'd5);
`endif
    pulse_ack(); pulse_eoi();

    // Mask withdrawal of source 4
    wr(2'd0, 8'h10);
    pulse_irq(8'h10); step(); step();
    look(); chk("t3_req", irq, 3'd4);
    wr(2'd0, 8'h00);
    look(); chk("t3_int_w", interrupt, 1'b1);
    step();
    look(); chk("t3_int_w1", interrupt, 1'b0);
`ifdef MCU0_INTC_ROTATE_EN
    rd("t3_stat", 2'd2, 8'h14);
`else
    rd("t3_stat", 2'd2, 8'h04);
`endif
    rd("t3_pend", 2'd1, 8'h10);
    wr(2'd1, 8'h10);

    // Masked source 6, then enable
    pulse_irq(8'h40); step(); step();
    look(); chk("t4_int_masked", interrupt, 1'b0); rd("t4_pend", 2'd1, 8'h40);
    wr(2'd0, 8'h40);
    look(); chk("t4_int_w", interrupt, 1'b0);
    step();
    look(); chk("t4_int", interrupt, 1'b1); chk("t4_irq", irq, 3'd6);
    pulse_ack();

    // Stray ack in service plus a new edge on 1
    wr(2'd0, 8'h42);
    ack = 1'b1; irq_in = 8'h02; step(); ack = 1'b0; irq_in = 8'h00; step();
`ifdef MCU0_INTC_ROTATE_EN
    look(); rd("t5_stat", 2'd2, 8'h96);
`else
    look(); rd("t5_stat", 2'd2, 8'h86);
`endif
    rd("t5_pend", 2'd1, 8'h02);
    pulse_eoi();
    look(); chk("t5_int_e", interrupt, 1'b0);
    step();
    look(); chk("t5_int_e1", interrupt, 1'b1); chk("t5_irq", irq, 3'd1);
    pulse_ack(); pulse_eoi();
    pulse_eoi();
    look(); chk("t5_stray_int", interrupt, 1'b0);
`ifdef MCU0_INTC_ROTATE_EN
    rd("t5_stray_stat", 2'd2, 8'h09);
`else
    rd("t5_stray_stat", 2'd2, 8'h01);
`endif

    // Asynchronous reset mid-REQ
    wr(2'd0, 8'h80);
    pulse_irq(8'h80); step(); step();
    look(); chk("t6_req", irq, 3'd7);
    #2;
    cfg_addr = 2'd0;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_int", interrupt, 1'b0);
    chk("t6_rst_irq", irq, 3'd0);
    chk("t6_rst_mask", cfg_rdata, 8'h00);
    step();
    reset_n = 1'b1;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int b = 1; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) irq_in[b] = ~irq_in[b];
      end
      if ($urandom_range(0, 15) == 0) irq_in[0] = ~irq_in[0];
      ack = (m_st == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      eoi = (m_st == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_wdata = 8'($urandom);
      if (c == 1500) reset_n = 1'b0;
      if (c == 1502) reset_n = 1'b1;
      step();
    end
    ack = 1'b0; eoi = 1'b0; cfg_we = 1'b0;
    step();
    look();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
